gpio_bank: RTL

Parametrised memory-mapped GPIO peripheral: CHANNELS independent ports of DATA_WIDTH bits each, with per-bit direction control, two-stage input synchronisers and optional rising/falling edge capture with a level interrupt. Replaces the single fixed 8-bit input/output path of the multicycle datapath. Sits on the datapath's word-addressed load/store path next to the memory system. Register reads return one cycle after the address is presented.

---
 rtl/gpio_bank.sv | 112 +++++++++++
 1 files changed

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-channel OUT/DIR/IN/EDGE registers with two-stage pad synchronisers.
// Define GPIO_BANK_IRQ_EN to build the edge-capture, warm-up counter and level interrupt logic.
module gpio_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 2,
    parameter int ADDR_WIDTH = $clog2(CHANNELS) + 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          Address_i,
    input  logic                           Write_Enable_i,
    input  logic [31:0]                    Write_Data_i,
    output logic [31:0]                    Read_Data_o,
    input  logic [CHANNELS*DATA_WIDTH-1:0] GPIO_i,
    output logic [CHANNELS*DATA_WIDTH-1:0] GPIO_o,
    output logic [CHANNELS*DATA_WIDTH-1:0] GPIO_oe,
    output logic                           IRQ_o
);

    typedef logic [CHANNELS-1:0][DATA_WIDTH-1:0] bank_t;

    bank_t                 out_q, dir_q, sync1_q, sync2_q;
    logic [ADDR_WIDTH-1:0] ch_sel;
    logic [1:0]            reg_off;
    logic [DATA_WIDTH-1:0] wdata, rd_mux;
    logic [31:0]           wdata_unused;

    assign ch_sel       = Address_i >> 2;
    assign reg_off      = Address_i[1:0];
    assign wdata        = Write_Data_i[DATA_WIDTH-1:0];
    assign wdata_unused = Write_Data_i;
    assign GPIO_o       = out_q;
    assign GPIO_oe      = dir_q;

`ifdef GPIO_BANK_IRQ_EN
    logic [1:0] warm_q;
    bank_t      prev_q, edge_q, edge_new, edge_clr;
    logic       irq_q;

    // Capture stays off until the synchronisers and prev hold real pad history.
    always_comb begin
        edge_new = '0;
        edge_clr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            edge_new[c] = (sync2_q[c] ^ prev_q[c]) & ~dir_q[c]
                          & {DATA_WIDTH{warm_q == 2'd3}};
            if (Write_Enable_i && ch_sel == ADDR_WIDTH'(c) && reg_off == 2'd3)
                edge_clr[c] = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warm_q <= 2'd0;
            prev_q <= '0;
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= sync2_q;
            if (warm_q != 2'd3)
                warm_q <= warm_q + 2'd1;
            edge_q <= (edge_q & ~edge_clr) | edge_new;
            irq_q  <= |(edge_q & ~dir_q);
        end
    end

    assign IRQ_o = irq_q;
`else
    assign IRQ_o = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_sel == ADDR_WIDTH'(c)) begin
                case (reg_off)
                    2'd0:    rd_mux = out_q[c];
                    2'd1:    rd_mux = dir_q[c];
                    2'd2:    rd_mux = sync2_q[c];
`ifdef GPIO_BANK_IRQ_EN
                    default: rd_mux = edge_q[c];
`else
                    default: rd_mux = '0;
`endif
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            dir_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            Read_Data_o <= '0;
        end else begin
            sync1_q     <= GPIO_i;
            sync2_q     <= sync1_q;
            Read_Data_o <= 32'(rd_mux);
            for (int c = 0; c < CHANNELS; c++) begin
                if (Write_Enable_i && ch_sel == ADDR_WIDTH'(c)) begin
                    if (reg_off == 2'd0)
                        out_q[c] <= wdata;
                    if (reg_off == 2'd1)
                        dir_q[c] <= wdata;
                end
            end
        end
    end

endmodule
